seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Runtime-programmable serial bit-sequence detector with a Moore-style registered match flag.
//  Pattern, pattern length and overlap/non-overlap mode are loaded at runtime.
//  Replaces fixed-pattern hard-coded detectors on serial framing/sync paths.
//  Also counts matches for status readout.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (>=2)
//  LEN_W    4   width of cfg_len; must hold MAX_LEN ($clog2(MAX_LEN+1))
//  CNT_W    16  width of saturating match counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-low
//  x            in   1        serial data bit
//  x_valid      in   1        x is sampled on this edge only when high
//  cfg_load     in   1        load-config strobe (single cycle)
//  cfg_pattern  in   MAX_LEN  pattern; bit [cfg_len-1] = first bit received, bit [0] = last
//  cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping detection, 0 = non-overlapping
//  z            out  1        match flag (registered)
//  match_cnt    out  CNT_W    matches since reset/config load, saturating
//  cfg_err      out  1        one-cycle pulse: illegal cfg_len rejected
//  configured   out  1        high once a legal config is held
// BEHAVIOUR
//  Reset (rst=0, async): state=UNCFG; z=0, match_cnt=0, cfg_err=0, configured=0.
//   History, fill counter and held config cleared. Mid-operation reset aborts a partial match.
//  States: UNCFG, RUN, HIT. configured=1 in RUN and HIT.
//   UNCFG: x ignored. Legal cfg_load -> RUN.
//   RUN:   match on edge -> HIT, else stay in RUN.
//   HIT:   z=1. Next edge -> HIT if another match, else RUN. z=0 in UNCFG/RUN.
//  cfg_load, legal length (1<=cfg_len<=MAX_LEN), any state:
//   latch pattern/len/overlap; clear history, fill and match_cnt; next state RUN.
//   x_valid on the same edge is dropped.
//  cfg_load, illegal length (0 or >MAX_LEN):
//   config, state, history, fill and count unchanged; x_valid on that edge also dropped.
//   cfg_err=1 for the following cycle only.
//  Shift, on each edge with x_valid=1 and no cfg_load, in RUN or HIT:
//   hist_n = {hist[MAX_LEN-2:0], x}; fill_n = min(fill+1, len).
//  Match when fill_n==len && hist_n[len-1:0]==pattern[len-1:0] (bits above len ignored).
//  On match:
//   z=1 the cycle after the edge sampling the final pattern bit (latency 1 clk).
//   match_cnt += 1, holds at 2^CNT_W-1.
//   non-overlap: fill <= 0 (next match needs len fresh bits).
//   overlap: fill stays at len, history kept.
//  x_valid=0: no shift, fill held. z drops to 0 the following cycle (HIT->RUN).
//  len=1: every bit equal to pattern[0] matches, in both modes.
//  Back-to-back matches (overlap, or len=1) hold z high across consecutive cycles.
// TESTING
//  T1 reset then x_valid stream with no cfg_load -> z=0, match_cnt=0, configured=0.
//  T2 pattern=4'b1010, len=4, overlap=0, stream 1,0,1,0,1,0,0 ->
//     z pulses once, the cycle after the 4th bit; match_cnt=1.
//  T3 same config, overlap=1, same stream -> z after bits 4 and 6; match_cnt=2.
//  T4 len=1, pattern=1, stream 1,1,1 with x_valid gapped 1-0-1-0-1 ->
//     three 1-cycle z pulses; match_cnt=3.
//  T5 cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses each time; prior config still
//     matches. Next: legal cfg_load with x_valid=1 on the same edge -> bit dropped, match_cnt=0.
//  T6 CNT_W=2, 5 matches -> match_cnt=3. Assert rst mid-pattern (after 3 of 4 bits) ->
//     all outputs 0 immediately; no match after release until a new cfg_load.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with a registered match flag,
// selectable overlap mode and a saturating match counter.
module seq_detect_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err,
  output logic               configured
);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    HIT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               z_q, z_d;
  logic               cfgd_q, cfgd_d;

  logic               cfg_legal;
  logic               shift_en;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  // History window including the bit arriving this edge; only the low len bits are compared.
  always_comb begin
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    shift_en  = x_valid && !cfg_load && (state_q != UNCFG);
    hist_n    = {hist_q, x};
    fill_n    = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    len_mask  = (MAX_LEN'(1) << len_q) - MAX_LEN'(1);
    hit       = shift_en && (fill_n == len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (cfg_load) begin
      if (cfg_legal) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
        cnt_d   = '0;
        state_d = RUN;
      end else begin
        err_d = 1'b1;
      end
    end else if (shift_en) begin
      hist_d = hist_n[MAX_LEN-2:0];
      if (hit) begin
        fill_d  = ovl_q ? len_q : '0;
        cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = HIT;
      end else begin
        fill_d  = fill_n;
        state_d = RUN;
      end
    end else if (state_q == HIT) begin
      state_d = RUN;
    end

    z_d    = (state_d == HIT);
    cfgd_d = (state_d != UNCFG);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNCFG;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      z_q     <= 1'b0;
      cfgd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      z_q     <= z_d;
      cfgd_q  <= cfgd_d;
    end
  end

  assign z          = z_q;
  assign match_cnt  = cnt_q;
  assign cfg_err    = err_q;
  assign configured = cfgd_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: vector tables fed through an expected-result queue,
// plus a hand-driven asynchronous reset in the middle of a pattern.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       x, x_valid, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic        z1, err1, cfgd1;
  logic [15:0] cnt1;
  logic        z2, err2, cfgd2;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z1), .match_cnt(cnt1), .cfg_err(err1), .configured(cfgd1)
  );

  seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z2), .match_cnt(cnt2), .cfg_err(err2), .configured(cfgd2)
  );

  typedef struct {
    bit          d2;
    logic        ld;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic        xv;
    logic        xb;
    logic        ez;
    logic [15:0] ecnt;
    logic        eerr;
    logic        ecfg;
  } vec_t;

  typedef struct {
    logic        ez;
    logic [15:0] ecnt;
    logic        eerr;
    logic        ecfg;
  } exp_t;

  vec_t vec_a[$];
  vec_t vec_b[$];
  vec_t vec_c[$];
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;
  int vec_idx = 0;

  function automatic vec_t mk(bit d2, logic ld, logic [7:0] pat, logic [3:0] len, logic ovl,
                              logic xv, logic xb, logic ez, logic [15:0] ec, logic ee,
                              logic ecf);
    vec_t v;
    v.d2 = d2; v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.xv = xv; v.xb = xb;
    v.ez = ez; v.ecnt = ec; v.eerr = ee; v.ecfg = ecf;
    return v;
  endfunction

  // Data bit with x_valid high
  function automatic vec_t B(bit d2, logic xb, logic ez, logic [15:0] ec, logic ecf);
    return mk(d2, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb, ez, ec, 1'b0, ecf);
  endfunction

  // Idle cycle, x_valid low
  function automatic vec_t G(bit d2, logic [15:0] ec, logic ecf);
    return mk(d2, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, ec, 1'b0, ecf);
  endfunction

  // Legal configuration load
  function automatic vec_t L(bit d2, logic [7:0] pat, logic [3:0] len, logic ovl, logic xv,
                             logic xb);
    return mk(d2, 1'b1, pat, len, ovl, xv, xb, 1'b0, 16'd0, 1'b0, 1'b1);
  endfunction

  // Illegal configuration load with a valid data bit on the same edge
  function automatic vec_t I(bit d2, logic [3:0] len, logic xb, logic [15:0] ec);
    return mk(d2, 1'b1, 8'hFF, len, 1'b1, 1'b1, xb, 1'b0, ec, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    cfg_load    = v.ld;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    x_valid     = v.xv;
    x           = v.xb;
    sb.push_back('{ez: v.ez, ecnt: v.ecnt, eerr: v.eerr, ecfg: v.ecfg});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (v.d2) begin
      chk($sformatf("v%0d.z", vec_idx), {15'd0, z2}, {15'd0, e.ez});
      chk($sformatf("v%0d.cnt", vec_idx), {14'd0, cnt2}, e.ecnt);
      chk($sformatf("v%0d.err", vec_idx), {15'd0, err2}, {15'd0, e.eerr});
      chk($sformatf("v%0d.cfg", vec_idx), {15'd0, cfgd2}, {15'd0, e.ecfg});
    end else begin
      chk($sformatf("v%0d.z", vec_idx), {15'd0, z1}, {15'd0, e.ez});
      chk($sformatf("v%0d.cnt", vec_idx), cnt1, e.ecnt);
      chk($sformatf("v%0d.err", vec_idx), {15'd0, err1}, {15'd0, e.eerr});
      chk($sformatf("v%0d.cfg", vec_idx), {15'd0, cfgd1}, {15'd0, e.ecfg});
    end
    vec_idx++;
  endtask

  initial begin
    // unconfigured: stream is ignored
    repeat (3) vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b0));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd0, 1'b0));
    // 1010, len 4, non-overlap; stream 1,0,1,0,1,0,0
    vec_a.push_back(L(0, 8'h0A, 4'd4, 1'b0, 1'b0, 1'b0));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b1, 16'd1, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd1, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd1, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd1, 1'b1));
    // same pattern, overlapping
    vec_a.push_back(L(0, 8'h0A, 4'd4, 1'b1, 1'b0, 1'b0));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b1, 16'd1, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd1, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b1, 16'd2, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd2, 1'b1));
    // len 1, pattern 1, gapped x_valid
    vec_a.push_back(L(0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0));
    vec_a.push_back(B(0, 1'b1, 1'b1, 16'd1, 1'b1));
    vec_a.push_back(G(0, 16'd1, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b1, 16'd2, 1'b1));
    vec_a.push_back(G(0, 16'd2, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b1, 16'd3, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd3, 1'b1));
    // illegal lengths interleaved with 1,0,1,0: their bits must be dropped
    vec_a.push_back(L(0, 8'h0A, 4'd4, 1'b0, 1'b0, 1'b0));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(I(0, 4'd0, 1'b1, 16'd0));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(I(0, 4'd9, 1'b0, 16'd0));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b1, 16'd1, 1'b1));
    // legal load with x_valid on the same edge: leading 1 dropped
    vec_a.push_back(L(0, 8'h0A, 4'd4, 1'b0, 1'b1, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_a.push_back(B(0, 1'b0, 1'b1, 16'd1, 1'b1));

    // 2-bit counter saturation, then a partial pattern before reset
    vec_b.push_back(L(1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0));
    vec_b.push_back(B(1, 1'b1, 1'b1, 16'd1, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b1, 16'd2, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b1, 16'd3, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b1, 16'd3, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b1, 16'd3, 1'b1));
    vec_b.push_back(L(1, 8'h0A, 4'd4, 1'b0, 1'b0, 1'b0));
    vec_b.push_back(B(1, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_b.push_back(B(1, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_b.push_back(B(1, 1'b0, 1'b1, 16'd1, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b0, 16'd1, 1'b1));
    vec_b.push_back(B(1, 1'b0, 1'b0, 16'd1, 1'b1));
    vec_b.push_back(B(1, 1'b1, 1'b0, 16'd1, 1'b1));

    // after reset: ignored until reconfigured
    vec_c.push_back(B(1, 1'b0, 1'b0, 16'd0, 1'b0));
    vec_c.push_back(B(1, 1'b1, 1'b0, 16'd0, 1'b0));
    vec_c.push_back(B(1, 1'b0, 1'b0, 16'd0, 1'b0));
    vec_c.push_back(B(1, 1'b1, 1'b0, 16'd0, 1'b0));
    vec_c.push_back(B(1, 1'b0, 1'b0, 16'd0, 1'b0));
    vec_c.push_back(L(1, 8'h0A, 4'd4, 1'b0, 1'b0, 1'b0));
    vec_c.push_back(B(1, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_c.push_back(B(1, 1'b0, 1'b0, 16'd0, 1'b1));
    vec_c.push_back(B(1, 1'b1, 1'b0, 16'd0, 1'b1));
    vec_c.push_back(B(1, 1'b0, 1'b1, 16'd1, 1'b1));

    rst = 1'b0; rst2 = 1'b0;
    x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    #12;
    chk("rst.z", {15'd0, z1}, 16'd0);
    chk("rst.cnt", cnt1, 16'd0);
    chk("rst.err", {15'd0, err1}, 16'd0);
    chk("rst.cfg", {15'd0, cfgd1}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vec_a[i]) apply(vec_a[i]);

    @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b1;
    foreach (vec_b[i]) apply(vec_b[i]);

    // asynchronous reset between edges, three bits into 1010
    #2;
    rst2 = 1'b0;
    #1;
    chk("midrst.z", {15'd0, z2}, 16'd0);
    chk("midrst.cnt", {14'd0, cnt2}, 16'd0);
    chk("midrst.err", {15'd0, err2}, 16'd0);
    chk("midrst.cfg", {15'd0, cfgd2}, 16'd0);
    @(negedge clk);
    rst2 = 1'b1;

    foreach (vec_c[i]) apply(vec_c[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
